vx_tcu_fedp_seq: RTL and testbench
==================================

// Module: vx_tcu_fedp_seq
// PURPOSE
//  Initiator/collector for the tensor-core FEDP dot-product pipeline. Accepts
//  operand beats via valid/ready and drives the FEDP input ports. Tracks each beat
//  through the fixed FEDP latency with a tag, then captures d_val into an in-order
//  response FIFO. Credit-based admission means the FEDP never needs to stall.
// PARAMETERS
//  N        1   32-bit operand words per row/col (2*N 16-bit lanes)
//  XLEN     32  datapath word width
//  LATENCY  10  FEDP total latency in cycles (10 for N=1); must be >=1
//  DEPTH    16  response FIFO entries; must be >=2
//  TAGW     8   request tag width
// PORTS
//  clk          in   1         clock
//  reset_n      in   1         async reset, active-low
//  req_valid    in   1         operand beat valid
//  req_ready    out  1         beat accepted when valid&ready
//  req_fmt_s    in   3         source fmt: 1=fp16, 2=bf16, 3=tf32
//  req_fmt_d    in   3         dest fmt (forwarded only)
//  req_a_row    in   N*XLEN    A row operands
//  req_b_col    in   N*XLEN    B column operands
//  req_c_val    in   XLEN      accumulator input (fp32)
//  req_tag      in   TAGW      tag returned with the result
//  fedp_enable  out  1         FEDP pipeline enable
//  fedp_fmt_s   out  3         to FEDP fmt_s
//  fedp_fmt_d   out  3         to FEDP fmt_d
//  fedp_a_row   out  N*XLEN    to FEDP a_row
//  fedp_b_col   out  N*XLEN    to FEDP b_col
//  fedp_c_val   out  XLEN      to FEDP c_val
//  fedp_d_val   in   XLEN      from FEDP d_val
//  rsp_valid    out  1         result valid
//  rsp_ready    in   1         result popped when valid&ready
//  rsp_d_val    out  XLEN      fp32 result
//  rsp_tag      out  TAGW      tag of the result
//  busy         out  1         beats in flight or FIFO not empty
// BEHAVIOUR
//  - Reset (reset_n=0, async): credits=DEPTH, valid/tag shift register cleared,
//    FIFO empty. Outputs: rsp_valid=0, busy=0, fedp_enable=0, rsp_d_val/rsp_tag=0.
//    req_ready=0 while in reset; it goes to 1 on the first clock after release.
//  - fedp_enable=1 on every cycle outside reset. No backpressure into the FEDP.
//  - fedp_* operand ports = req_* combinationally (0-cycle). The FEDP samples on
//    every edge; non-fired cycles are bubbles tracked by the valid pipe.
//  - fire = req_valid & req_ready; req_ready = (credits != 0).
//  - pop = rsp_valid & rsp_ready.
//  - credits: -1 on fire only, +1 on pop only, unchanged on fire & pop together.
//    Invariant: credits + in-flight + FIFO occupancy == DEPTH. Credits never
//    exceed DEPTH and never go below 0.
//  - Valid/tag pipe is LATENCY stages deep. A beat fired in cycle t presents
//    fedp_d_val in cycle t+LATENCY. Then {d_val, tag} is written to the FIFO on
//    that edge, and rsp_valid=1 earliest in cycle t+LATENCY+1.
//  - FIFO: registered head. Write and read in the same cycle are allowed at any
//    occupancy, including full (pop frees a slot) and empty (no bypass).
//    Write-when-full cannot occur by construction; the bench asserts this.
//  - Results are strictly in issue order. Back-to-back fires sustain 1 beat/cycle
//    while rsp_ready=1.
//  - Invalid fmt_s (0,4-7) is accepted. Its d_val is undefined, but the tag is
//    still returned and credits are still restored.
//  - rsp_valid deasserts only on pop. rsp_d_val/rsp_tag are stable while
//    valid & !ready.
//  - Reset mid-operation: all in-flight and buffered beats are dropped. After
//    release, no stale result is ever emitted.
// CONFIGURATION
//  VX_TCU_SEQ_PERF_EN defined:
//    - Adds outputs perf_issued[31:0] (count of fires) and perf_stalls[31:0]
//      (cycles with req_valid & !req_ready).
//    - Both are 0 on reset and wrap at 2^32.
//  VX_TCU_SEQ_PERF_EN undefined: those ports and counters do not exist.
//    Functional behaviour is identical either way.
// TESTING
//  1 fp16: a=0x3C00_3C00, b=0x4000_4000, c=0, tag=5 at t
//    -> rsp_d_val=0x40800000, tag=5, rsp_valid at t+11.
//  2 16 back-to-back bf16 beats (a=b=0x3F80_3F80, c=0x3F800000), rsp_ready=1
//    -> 16 results 0x40400000, one per cycle, tags in order, req_ready held 1.
//  3 rsp_ready=0, req_valid held
//    -> exactly 16 fires, then req_ready=0. Raise rsp_ready -> 16 results in order.
//    Next fire occurs the cycle after the first pop.
//  4 credits=0 with pop and req_valid in the same cycle
//    -> no fire that cycle; fire next cycle; credit invariant holds every cycle.
//  5 reset_n pulse with 5 beats in flight and 3 buffered
//    -> rsp_valid=0 immediately; after release, 20 idle cycles give no rsp_valid,
//    req_ready=1, busy=0.
//  6 with VX_TCU_SEQ_PERF_EN, run scenario 3 with 4 extra stalled cycles
//    -> perf_issued=16, perf_stalls=4.

Source files
------------

// File: rtl/vx_tcu_fedp_seq.sv
// Issue/collect sequencer for the fixed-latency FEDP dot-product pipeline: credit admission,
// valid/tag shadow pipe, in-order response FIFO. Perf counters under VX_TCU_SEQ_PERF_EN.
module vx_tcu_fedp_seq #(
  parameter int N       = 1,
  parameter int XLEN    = 32,
  parameter int LATENCY = 10,
  parameter int DEPTH   = 16,
  parameter int TAGW    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt_s,
  input  logic [2:0]        req_fmt_d,
  input  logic [N*XLEN-1:0] req_a_row,
  input  logic [N*XLEN-1:0] req_b_col,
  input  logic [XLEN-1:0]   req_c_val,
  input  logic [TAGW-1:0]   req_tag,
  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [2:0]        fedp_fmt_d,
  output logic [N*XLEN-1:0] fedp_a_row,
  output logic [N*XLEN-1:0] fedp_b_col,
  output logic [XLEN-1:0]   fedp_c_val,
  input  logic [XLEN-1:0]   fedp_d_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_d_val,
  output logic [TAGW-1:0]   rsp_tag,
  output logic              busy
`ifdef VX_TCU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stalls
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = XLEN + TAGW;

  logic                         run_q, run_d;
  logic [CW-1:0]                credits_q, credits_d, count_q, count_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LATENCY-1:0]           vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][TAGW-1:0] tag_pipe_q, tag_pipe_d;
  logic [DEPTH-1:0][EW-1:0]     mem_q, mem_d;
  logic                         fire, pop, wr;

  // The FEDP never stalls, so operands go straight through; bubbles are just !fire.
  assign fedp_enable = run_q;
  assign fedp_fmt_s  = req_fmt_s;
  assign fedp_fmt_d  = req_fmt_d;
  assign fedp_a_row  = req_a_row;
  assign fedp_b_col  = req_b_col;
  assign fedp_c_val  = req_c_val;

  assign req_ready = run_q & (credits_q != '0);
  assign fire      = req_valid & req_ready;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign wr        = vld_pipe_q[LATENCY-1];
  assign rsp_d_val = mem_q[rd_ptr_q][EW-1:TAGW];
  assign rsp_tag   = mem_q[rd_ptr_q][TAGW-1:0];
  assign busy      = (|vld_pipe_q) | rsp_valid;

  always_comb begin
    run_d      = 1'b1;
    credits_d  = credits_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    vld_pipe_d = vld_pipe_q;
    tag_pipe_d = tag_pipe_q;

    vld_pipe_d[0] = fire;
    tag_pipe_d[0] = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    // A credit is held from issue until the result leaves the FIFO, so writes never overflow.
    if (fire && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !fire) credits_d = credits_q + CW'(1);

    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr) count_d = count_q - CW'(1);

    if (wr) begin
      mem_d[wr_ptr_q] = {fedp_d_val, tag_pipe_q[LATENCY-1]};
      wr_ptr_d        = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      credits_q  <= CW'(DEPTH);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      run_q      <= run_d;
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d, perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stalls_d = perf_stalls_q;
    if (fire)                   perf_issued_d = perf_issued_q + 32'd1;
    if (req_valid && !req_ready) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Directed bench for vx_tcu_fedp_seq with a fixed-latency FEDP stand-in and an in-order scoreboard.
module tb_vx_tcu_fedp_seq;
  localparam int N = 1, XLEN = 32, LAT = 10, DEPTH = 16, TAGW = 8;

  logic              clk = 1'b0, reset_n = 1'b1;
  logic              req_valid = 1'b0, req_ready, rsp_ready = 1'b0;
  logic [2:0]        req_fmt_s = 3'd1, req_fmt_d = 3'd2;
  logic [N*XLEN-1:0] req_a_row = '0, req_b_col = '0;
  logic [XLEN-1:0]   req_c_val = '0;
  logic [TAGW-1:0]   req_tag = '0;
  logic              fedp_enable, rsp_valid, busy;
  logic [2:0]        fedp_fmt_s, fedp_fmt_d;
  logic [N*XLEN-1:0] fedp_a_row, fedp_b_col;
  logic [XLEN-1:0]   fedp_c_val, fedp_d_val, rsp_d_val;
  logic [TAGW-1:0]   rsp_tag;
`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0]       perf_issued, perf_stalls;
`endif

  always #5 clk = ~clk;

  vx_tcu_fedp_seq #(.N(N), .XLEN(XLEN), .LATENCY(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
    .req_a_row(req_a_row), .req_b_col(req_b_col), .req_c_val(req_c_val), .req_tag(req_tag),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val),
    .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d_val(rsp_d_val), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef VX_TCU_SEQ_PERF_EN
    , .perf_issued(perf_issued), .perf_stalls(perf_stalls)
`endif
  );

  // FEDP stand-in: exact results for the directed vectors, an input hash otherwise.
  function automatic logic [31:0] fedp_f(input logic [2:0] f, input logic [31:0] a, b, c);
    if (f == 3'd1 && a == 32'h3C00_3C00 && b == 32'h4000_4000 && c == 32'h0) return 32'h4080_0000;
    if (f == 3'd2 && a == 32'h3F80_3F80 && b == 32'h3F80_3F80 && c == 32'h3F80_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ c ^ {29'd0, f};
  endfunction

  logic [31:0] st_q [LAT];
  always @(posedge clk) begin
    st_q[0] <= fedp_f(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
    for (int i = 1; i < LAT; i++) st_q[i] <= st_q[i-1];
  end
  assign fedp_d_val = st_q[LAT-1];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tg, got, exp);
  endtask

  // Per-cycle monitor: scoreboard, credit rule, hold-stability, occupancy bound.
  logic [39:0] sb[$];
  int          nfire = 0, npop = 0;
  bit          chk_on = 0, hold = 0;
  logic [39:0] held = '0;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      sb.delete(); nfire = 0; npop = 0; hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", {rsp_d_val, rsp_tag}, held);
      end
      if (chk_on) begin
        chk("ready_credit", req_ready, (DEPTH - (nfire - npop)) != 0);
        chk("fedp_enable", fedp_enable, 1);
      end
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("rsp_order", {rsp_d_val, rsp_tag}, sb[0]);
          void'(sb.pop_front());
        end
        npop++;
      end
      if (req_valid && req_ready) begin
        sb.push_back({fedp_f(req_fmt_s, req_a_row, req_b_col, req_c_val), req_tag});
        nfire++;
      end
      chk("no_overflow", (nfire - npop) <= DEPTH, 1);
      hold = rsp_valid && !rsp_ready;
      held = {rsp_d_val, rsp_tag};
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk_on = 0; reset_n = 0; req_valid = 0; rsp_ready = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fedp_enable", fedp_enable, 0);
    chk("rst_rsp_d_val", rsp_d_val, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
`ifdef VX_TCU_SEQ_PERF_EN
    chk("rst_perf_issued", perf_issued, 0);
    chk("rst_perf_stalls", perf_stalls, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk("rel_ready_low", req_ready, 0);
    cyc();
    chk("rel_ready_high", req_ready, 1);
    chk_on = 1;
  endtask

  task automatic drain(input string tg);
    int k = 0;
    rsp_ready = 1;
    while ((busy || sb.size() != 0) && k < 200) begin @(negedge clk); k++; end
    chk(tg, k < 200, 1);
  endtask

  initial begin
    int lat, first, cnt, last, nrdy, nf;
    #1;
    do_reset();

    // 1: single fp16 beat, latency and forwarding
    rsp_ready = 1; req_fmt_s = 3'd1; req_fmt_d = 3'd2;
    req_a_row = 32'h3C00_3C00; req_b_col = 32'h4000_4000; req_c_val = 32'h0; req_tag = 8'd5;
    req_valid = 1;
    @(negedge clk);
    chk("t1_fire", req_ready, 1);
    chk("t1_fwd_a", fedp_a_row, 32'h3C00_3C00);
    chk("t1_fwd_b", fedp_b_col, 32'h4000_4000);
    chk("t1_fwd_c", fedp_c_val, 32'h0);
    chk("t1_fwd_fmt", {fedp_fmt_s, fedp_fmt_d}, {3'd1, 3'd2});
    cyc(); req_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("t1_busy", busy, 1);
      if (rsp_valid) begin
        lat = k;
        chk("t1_d_val", rsp_d_val, 32'h4080_0000);
        chk("t1_tag", rsp_tag, 5);
      end
    end
    chk("t1_latency", lat, 11);
    drain("t1_drain");

    // 2: 16 back-to-back bf16 beats at full rate
    cyc();
    req_fmt_s = 3'd2; req_a_row = 32'h3F80_3F80; req_b_col = 32'h3F80_3F80;
    req_c_val = 32'h3F80_0000; req_tag = 8'h10; req_valid = 1;
    first = -1; cnt = 0; last = -1; nrdy = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j < 16 && req_ready) nrdy++;
      if (rsp_valid) begin
        if (first < 0) begin first = j; chk("t2_d_val", rsp_d_val, 32'h4040_0000); end
        cnt++; last = j;
      end
      cyc();
      if (j < 15) req_tag = 8'h11 + 8'(j);
      else req_valid = 0;
    end
    chk("t2_ready_held", nrdy, 16);
    chk("t2_first", first, 11);
    chk("t2_count", cnt, 16);
    chk("t2_last", last, 26);

    // invalid source format still returns its tag
    req_fmt_s = 3'd5; req_tag = 8'h77; req_c_val = 32'h1234_5678; req_valid = 1;
    @(negedge clk);
    chk("inv_fire", req_ready, 1);
    cyc(); req_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; chk("inv_tag", rsp_tag, 8'h77); end
    end
    chk("inv_latency", lat, 11);
    drain("inv_drain");

    // 3: no consumer: exactly DEPTH fires then stall (4 stalled cycles)
    cyc();
    do_reset();
    req_fmt_s = 3'd1; req_a_row = 32'h0101_0202; req_b_col = 32'h0303_0404;
    nf = 0; req_c_val = 0; req_tag = 8'h20; req_valid = 1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (req_ready) nf++;
      cyc();
      req_tag = 8'h20 + 8'(nf); req_c_val = 32'(nf);
    end
    req_valid = 0;
    @(negedge clk);
    chk("t3_fires", nf, 16);
    chk("t3_ready_low", req_ready, 0);
    chk("t3_busy", busy, 1);
    chk("t3_rsp_valid", rsp_valid, 1);
`ifdef VX_TCU_SEQ_PERF_EN
    chk("t6_perf_issued", perf_issued, 16);
    chk("t6_perf_stalls", perf_stalls, 4);
`endif

    // 4: pop and request together at zero credits: fire only on the next cycle
    cyc();
    rsp_ready = 1; req_valid = 1;
    @(negedge clk);
    chk("t4_pop", rsp_valid, 1);
    chk("t4_no_fire", req_ready, 0);
    cyc();
    @(negedge clk);
    chk("t4_fire_next", req_ready, 1);
    cyc(); req_valid = 0;
    drain("t3_drain");
    chk("t3_pops", npop, 17);

    // 5: reset with 3 buffered and 5 in flight
    cyc();
    do_reset();
    req_fmt_s = 3'd3;
    for (int j = 0; j < 3; j++) begin req_tag = 8'h40 + 8'(j); req_c_val = 32'(j); req_valid = 1; cyc(); end
    req_valid = 0;
    repeat (12) cyc();
    for (int j = 0; j < 5; j++) begin req_tag = 8'h50 + 8'(j); req_c_val = 32'(j + 8); req_valid = 1; cyc(); end
    req_valid = 0;
    chk("t5_pre_valid", rsp_valid, 1);
    chk("t5_pre_busy", busy, 1);
    do_reset();
    rsp_ready = 1; cnt = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) cnt++; end
    chk("t5_no_stale", cnt, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
